// File: rtl/serial_link_drain_pkg.sv
// Package for the serial-link FIFO drain controller.
// Holds the sequencer state encoding and the bus word-size helper.
package serial_link_drain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FINISH
    } drain_state_e;

    // Byte lanes in one bus word; also the destination address stride.
    function automatic int unsigned word_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

    localparam int unsigned BYTES_PER_WORD = word_bytes(32);

endpackage

// File: rtl/serial_link_fifo_drain_ctrl.sv
// Drains the serial-link receive FIFO into system memory.
// The controller pops one word from the FIFO reader port (OBI master), then writes it to
// dst_base + i*BYTES_PER_WORD through the memory port (OBI master), repeating for len words.
// There is at most one outstanding transaction per port.
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   start_i, abort_i                 control pulses from the register file
//   dst_base_i, len_i                transfer setup, latched on an accepted start
//   busy_o, done_o, aborted_o        status; done_o is a one-cycle pulse
//   count_o                          words written in the current/last transfer
//   fifo_*                           OBI read master towards the FIFO wrapper
//   mem_*                            OBI write master towards the system bus
module serial_link_fifo_drain_ctrl
    import serial_link_drain_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           CNT_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] FIFO_ADDR  = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [ADDR_WIDTH-1:0]   dst_base_i,
    input  logic [CNT_WIDTH-1:0]    len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    aborted_o,
    output logic [CNT_WIDTH-1:0]    count_o,
    output logic                    fifo_req_o,
    input  logic                    fifo_gnt_i,
    input  logic                    fifo_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   fifo_rdata_i,
    output logic [ADDR_WIDTH-1:0]   fifo_addr_o,
    output logic                    fifo_we_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o
);

    localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(word_bytes(DATA_WIDTH));

    drain_state_e          state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  abort_pend_q, abort_pend_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        aborted_d = aborted_q;
        count_d   = count_q;
        len_d     = len_q;
        addr_d    = addr_q;
        data_d    = data_q;

        // Abort is sticky for the rest of a transfer; in IDLE it is ignored, which also
        // makes start win when start and abort arrive together.
        abort_pend_d = (state_q != IDLE) && (abort_pend_q || abort_i);

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d     = len_i;
                    addr_d    = dst_base_i;
                    count_d   = '0;
                    aborted_d = 1'b0;
                    state_d   = (len_i == '0) ? FINISH : RD_REQ;
                end
            end
            RD_REQ: begin
                // fifo_req_o is masked while an abort is pending, so leaving here never
                // strands a granted pop.
                if (abort_pend_q) begin
                    state_d = FINISH;
                end else if (fifo_gnt_i) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (fifo_rvalid_i) begin
                    data_d  = fifo_rdata_i;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (mem_gnt_i) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (mem_rvalid_i) begin
                    count_d = count_q + CNT_WIDTH'(1);
                    addr_d  = addr_q + AddrStep;
                    if ((count_d == len_q) || abort_pend_q) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            FINISH: begin
                done_d    = 1'b1;
                aborted_d = abort_pend_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            count_q      <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            count_q      <= count_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign aborted_o = aborted_q;
    assign count_o   = count_q;

    assign fifo_req_o  = (state_q == RD_REQ) && !abort_pend_q;
    assign fifo_addr_o = FIFO_ADDR;
    assign fifo_we_o   = 1'b0;

    // Address and data only move in IDLE/WR_WAIT and RD_WAIT, so they hold during WR_REQ.
    assign mem_req_o   = (state_q == WR_REQ);
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = 1'b1;
    assign mem_be_o    = '1;
    assign mem_wdata_o = data_q;

endmodule

// File: tb/tb_serial_link_fifo_drain_ctrl.sv
// Bench for serial_link_fifo_drain_ctrl: bus responders model the FIFO and memory, a
// scoreboard holds the expected writes and completions, and a monitor checks them.
module tb_serial_link_fifo_drain_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] dst_base_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, aborted_o;
    logic [15:0] count_o;
    logic        fifo_req_o, fifo_gnt_i, fifo_rvalid_i;
    logic [31:0] fifo_rdata_i, fifo_addr_o;
    logic        fifo_we_o;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;

    serial_link_fifo_drain_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .dst_base_i   (dst_base_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .aborted_o    (aborted_o),
        .count_o      (count_o),
        .fifo_req_o   (fifo_req_o),
        .fifo_gnt_i   (fifo_gnt_i),
        .fifo_rvalid_i(fifo_rvalid_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_addr_o  (fifo_addr_o),
        .fifo_we_o    (fifo_we_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [15:0] count;
        logic        aborted;
    } done_t;

    wr_t         exp_wr[$];
    done_t       exp_done[$];
    logic [31:0] fifo_q[$];
    logic [31:0] hold_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int wr_seen = 0;
    int done_seen = 0;
    bit mem_force_low = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus responders: FIFO grants while non-empty, memory grants randomly; both answer
    // with rvalid one cycle after a granted request.
    bit ff, mf;
    initial begin
        fifo_gnt_i = 1'b0;
        fifo_rvalid_i = 1'b0;
        fifo_rdata_i = '0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        forever begin
            @(negedge clk_i);
            ff = fifo_req_o && fifo_gnt_i && rst_ni;
            mf = mem_req_o && mem_gnt_i && rst_ni;
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                ff = 1'b0;
                mf = 1'b0;
            end
            fifo_rvalid_i = ff;
            if (ff && fifo_q.size() != 0) fifo_rdata_i = fifo_q.pop_front();
            mem_rvalid_i = mf;
            fifo_gnt_i = (fifo_q.size() != 0);
            mem_gnt_i = !mem_force_low && ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every granted write and every done pulse against the scoreboard.
    bit          stall_prev = 1'b0;
    logic [31:0] prev_addr, prev_data;
    initial begin
        wr_t   w;
        done_t d;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (stall_prev && mem_req_o) begin
                    check("mem_addr_stable", mem_addr_o, prev_addr);
                    check("mem_wdata_stable", mem_wdata_o, prev_data);
                end
                if (mem_req_o) check("no_fifo_req_during_write", fifo_req_o, 1'b0);
                if (mem_req_o && mem_gnt_i) begin
                    wr_seen++;
                    check("write_expected", exp_wr.size() != 0, 1'b1);
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        check("write_addr", mem_addr_o, w.addr);
                        check("write_data", mem_wdata_o, w.data);
                    end
                end
                stall_prev = mem_req_o && !mem_gnt_i;
                prev_addr = mem_addr_o;
                prev_data = mem_wdata_o;
                if (done_o) begin
                    done_seen++;
                    check("done_expected", exp_done.size() != 0, 1'b1);
                    if (exp_done.size() != 0) begin
                        d = exp_done.pop_front();
                        check("done_count", count_o, d.count);
                        check("done_aborted", aborted_o, d.aborted);
                        check("done_busy_low", busy_o, 1'b0);
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Reference model: word i lands at base + 4*i (mod 2^32) with the i-th FIFO word.
    task automatic plan(input logic [31:0] base, input int n_words, input int n_written,
                        input bit ab, input bit to_fifo);
        for (int i = 0; i < n_words; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (to_fifo) fifo_q.push_back(w);
            else hold_q.push_back(w);
            if (i < n_written) exp_wr.push_back('{addr: base + 32'(4 * i), data: w});
        end
        exp_done.push_back('{count: 16'(n_written), aborted: ab});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_xfer(input logic [31:0] base, input logic [15:0] len, input bit ab);
        dst_base_i = base;
        len_i = len;
        start_i = 1'b1;
        abort_i = ab;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        dst_base_i = $urandom;
        len_i = 16'($urandom);
    endtask

    task automatic wait_done(input string name);
        int d0;
        int cyc;
        d0 = done_seen;
        cyc = 0;
        while (done_seen == d0 && cyc < 3000) begin
            tick();
            cyc++;
        end
        check({name, "_done_in_time"}, done_seen != d0, 1'b1);
        check({name, "_writes_drained"}, exp_wr.size(), 0);
    endtask

    task automatic wait_mem_req(input string name);
        int cyc;
        cyc = 0;
        while (!mem_req_o && cyc < 200) begin
            tick();
            cyc++;
        end
        check({name, "_mem_req_seen"}, mem_req_o, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        int          n;
        int          sz;
        int          w0;
        int          cyc;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_fifo_req", fifo_req_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check("rst_done", done_o, 1'b0);
        check("rst_aborted", aborted_o, 1'b0);
        check("rst_count", count_o, 16'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        check("const_fifo_addr", fifo_addr_o, 32'h0);
        check("const_fifo_we", fifo_we_o, 1'b0);
        check("const_mem_we", mem_we_o, 1'b1);
        check("const_mem_be", mem_be_o, 4'hF);

        // Four known words into 0x1000..0x100C.
        for (int i = 0; i < 4; i++) begin
            fifo_q.push_back(32'hA0A0_0000 + 32'(i));
            exp_wr.push_back('{addr: 32'h1000 + 32'(4 * i), data: 32'hA0A0_0000 + 32'(i)});
        end
        exp_done.push_back('{count: 16'd4, aborted: 1'b0});
        start_xfer(32'h1000, 16'd4, 1'b0);
        wait_done("basic4");
        check("basic4_count", count_o, 16'd4);
        check("basic4_fifo_empty", fifo_q.size(), 0);

        // Zero length: done two cycles after start, no bus traffic.
        exp_done.push_back('{count: 16'd0, aborted: 1'b0});
        start_xfer(32'h2000, 16'd0, 1'b0);
        check("len0_no_done_yet", done_o, 1'b0);
        check("len0_busy", busy_o, 1'b1);
        check("len0_no_fifo_req", fifo_req_o, 1'b0);
        check("len0_no_mem_req", mem_req_o, 1'b0);
        tick();
        check("len0_done_pulse", done_o, 1'b1);
        check("len0_not_busy", busy_o, 1'b0);
        tick();
        check("len0_done_one_cycle", done_o, 1'b0);
        check("len0_aborted", aborted_o, 1'b0);

        // Empty FIFO: request held until words arrive.
        base = 32'h0000_3000;
        plan(base, 2, 2, 1'b0, 1'b0);
        start_xfer(base, 16'd2, 1'b0);
        repeat (10) tick();
        check("empty_fifo_req_held", fifo_req_o, 1'b1);
        check("empty_busy", busy_o, 1'b1);
        check("empty_count", count_o, 16'd0);
        while (hold_q.size() != 0) fifo_q.push_back(hold_q.pop_front());
        wait_done("empty");

        // Memory grant held low: write stays stable, no further pops.
        mem_force_low = 1'b1;
        base = 32'h0000_4000;
        plan(base, 2, 2, 1'b0, 1'b1);
        start_xfer(base, 16'd2, 1'b0);
        wait_mem_req("stall");
        sz = fifo_q.size();
        repeat (5) begin
            tick();
            check("stall_mem_req_held", mem_req_o, 1'b1);
        end
        check("stall_no_extra_pop", fifo_q.size(), sz);
        mem_force_low = 1'b0;
        wait_done("stall");

        // Abort while the second of eight words is being written.
        base = 32'h0000_5000;
        plan(base, 8, 2, 1'b1, 1'b1);
        w0 = wr_seen;
        start_xfer(base, 16'd8, 1'b0);
        cyc = 0;
        while (wr_seen < w0 + 2 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("abort_second_write_seen", wr_seen, w0 + 2);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        wait_done("abort");
        check("abort_aborted_o", aborted_o, 1'b1);
        check("abort_count", count_o, 16'd2);
        check("abort_fifo_left", fifo_q.size(), 6);
        repeat (3) tick();
        fifo_q.delete();

        // Start and abort together in IDLE: start wins, aborted cleared.
        base = 32'h0000_6000;
        plan(base, 3, 3, 1'b0, 1'b1);
        start_xfer(base, 16'd3, 1'b1);
        wait_done("start_abort");
        check("start_abort_count", count_o, 16'd3);

        // Start while busy is ignored.
        base = 32'h0000_7000;
        plan(base, 3, 3, 1'b0, 1'b1);
        start_xfer(base, 16'd3, 1'b0);
        tick();
        start_xfer(32'h0, 16'd1, 1'b0);
        wait_done("busy_start");

        // Address wraps modulo 2^32.
        base = 32'hFFFF_FFF8;
        plan(base, 4, 4, 1'b0, 1'b1);
        start_xfer(base, 16'd4, 1'b0);
        wait_done("wrap");

        // Random transfers.
        for (int t = 0; t < 8; t++) begin
            base = {$urandom} & 32'hFFFF_FFFC;
            n = $urandom_range(1, 8);
            plan(base, n, n, 1'b0, 1'b1);
            start_xfer(base, 16'(n), 1'b0);
            wait_done("random");
            check("random_count", count_o, 16'(n));
        end

        // Reset during WR_REQ.
        mem_force_low = 1'b1;
        base = 32'h0000_8000;
        plan(base, 3, 3, 1'b0, 1'b1);
        start_xfer(base, 16'd3, 1'b0);
        wait_mem_req("reset");
        w0 = done_seen;
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_mem_req", mem_req_o, 1'b0);
        check("midrst_fifo_req", fifo_req_o, 1'b0);
        check("midrst_count", count_o, 16'd0);
        check("midrst_mem_addr", mem_addr_o, 32'd0);
        check("midrst_mem_wdata", mem_wdata_o, 32'd0);
        check("midrst_done", done_o, 1'b0);
        exp_wr.delete();
        exp_done.delete();
        fifo_q.delete();
        mem_force_low = 1'b0;
        repeat (2) tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) tick();
        check("midrst_no_done", done_seen, w0);
        base = 32'h0000_9000;
        plan(base, 3, 3, 1'b0, 1'b1);
        start_xfer(base, 16'd3, 1'b0);
        wait_done("after_reset");
        check("after_reset_count", count_o, 16'd3);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
